// File: rtl/fetch_stage_pkg.sv
// ============================================================================
// Module   : fetch_stage_pkg
// Purpose  : Shared constants and the fetch-to-decode uop type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Purpose  : Small synchronous FIFO with clear; head reads as zero when empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd;
    logic [c_PTR_W-1:0] r_wr;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (push && !pop) begin
                assert (r_cnt < c_CNT_W'(DEPTH));
            end
        end
    end

    // Storage needs no reset: head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (!rst && !clear && push) begin
            r_mem[r_wr] <= push_data;
        end
    end

    assign count = r_cnt;
    assign head  = (r_cnt != '0) ? r_mem[r_rd] : '0;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : PC owner, credit-limited imem requester and decode-side buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

import fetch_stage_pkg::*;

module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirectPc,
    output logic            imemReqValid,
    input  logic            imemReqReady,
    output logic [XLEN-1:0] imemReqAddr,
    input  logic            imemRespValid,
    input  logic [XLEN-1:0] imemRespData,
    output fetch_t          uopOut,
    output logic            valid,
    input  logic            stall
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_if_pc [DEPTH];
    logic [DEPTH-1:0]   r_if_kill;
    logic [c_PTR_W-1:0] r_if_rd;
    logic [c_PTR_W-1:0] r_if_wr;
    logic [c_CNT_W-1:0] r_if_cnt;

    logic [c_CNT_W-1:0] w_out_cnt;
    logic [c_CNT_W:0]   w_used;
    logic               w_req_fire;
    logic               w_resp_pop;
    logic               w_out_push;
    logic               w_out_pop;
    fetch_t             w_out_data;
    fetch_t             w_out_head;

    // Killed entries keep their credit until their response drains.
    assign w_used       = {1'b0, r_if_cnt} + {1'b0, w_out_cnt};
    assign imemReqValid = !rst && !redirect && (w_used < (c_CNT_W + 1)'(DEPTH));
    assign imemReqAddr  = r_pc;

    assign w_req_fire = imemReqValid && imemReqReady;
    assign w_resp_pop = imemRespValid && (r_if_cnt != '0);
    assign w_out_push = w_resp_pop && !r_if_kill[r_if_rd] && !redirect;
    assign w_out_pop  = valid && !stall && !redirect;
    assign w_out_data = '{pc: r_if_pc[r_if_rd], instr: imemRespData};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_if_kill <= '0;
            r_if_rd   <= '0;
            r_if_wr   <= '0;
            r_if_cnt  <= '0;
        end else begin
            if (redirect) begin
                r_pc      <= {redirectPc[XLEN-1:2], 2'b00};
                r_if_kill <= '1;
            end else if (w_req_fire) begin
                r_pc               <= r_pc + XLEN'(4);
                r_if_kill[r_if_wr] <= 1'b0;
                r_if_wr            <= r_if_wr + 1'b1;
            end
            if (w_resp_pop) begin
                r_if_rd <= r_if_rd + 1'b1;
            end
            case ({w_req_fire, w_resp_pop})
                2'b10:   r_if_cnt <= r_if_cnt + 1'b1;
                2'b01:   r_if_cnt <= r_if_cnt - 1'b1;
                default: r_if_cnt <= r_if_cnt;
            endcase
            if (imemRespValid) begin
                assert (r_if_cnt != '0);
            end
            if (w_req_fire && !w_resp_pop) begin
                assert (r_if_cnt < c_CNT_W'(DEPTH));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_req_fire) begin
            r_if_pc[r_if_wr] <= r_pc;
        end
    end

    fetch_queue #(
        .WIDTH ($bits(fetch_t)),
        .DEPTH (DEPTH)
    ) u_out_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (w_out_push),
        .push_data (w_out_data),
        .pop       (w_out_pop),
        .clear     (redirect),
        .count     (w_out_cnt),
        .head      (w_out_head)
    );

    assign valid  = (w_out_cnt != '0);
    assign uopOut = w_out_head;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench: table vectors, directed sequences, random run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

import fetch_stage_pkg::*;

module tb_fetch_stage;

    localparam int          c_DEPTH    = 2;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = '0;
    logic        imemReqValid;
    logic        imemReqReady = 1'b0;
    logic [31:0] imemReqAddr;
    logic        imemRespValid = 1'b0;
    logic [31:0] imemRespData = '0;
    fetch_t      uopOut;
    logic        valid;
    logic        stall = 1'b0;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (c_RESET_PC),
        .DEPTH    (c_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirectPc    (redirectPc),
        .imemReqValid  (imemReqValid),
        .imemReqReady  (imemReqReady),
        .imemReqAddr   (imemReqAddr),
        .imemRespValid (imemRespValid),
        .imemRespData  (imemRespData),
        .uopOut        (uopOut),
        .valid         (valid),
        .stall         (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          killed;
    } mreq_t;

    typedef struct {
        bit          stall;
        bit          ready;
        bit          resp;
        bit          redir;
        logic [31:0] rpc;
        bit          chk;
        bit          e_reqv;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    mreq_t       mem_q[$];
    logic [63:0] sb[$];
    logic [31:0] mpc = c_RESET_PC;
    int          nvec = 0;
    int          nfail = 0;

    bit          s_reqv;
    bit          s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [63:0] s_uop;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return ~a ^ 32'h1234_5678;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, compare against the model, then advance it.
    task automatic step(input bit s, input bit rdy, input bit rsp, input bit rd,
                        input logic [31:0] rpc, input bit r);
        bit    resp_now;
        bit    e_reqv;
        bit    e_valid;
        mreq_t h;
        @(negedge clk);
        rst          = r;
        stall        = s;
        imemReqReady = rdy;
        redirect     = rd;
        redirectPc   = rpc;
        resp_now     = !r && rsp && (mem_q.size() > 0);
        imemRespValid = resp_now;
        imemRespData  = resp_now ? mdata(mem_q[0].addr) : 32'h0;
        #1;
        e_reqv  = !r && !rd && ((mem_q.size() + sb.size()) < c_DEPTH);
        e_valid = (sb.size() > 0);
        check("reqValid", 64'(imemReqValid), 64'(e_reqv));
        if (e_reqv) check("reqAddr", 64'(imemReqAddr), 64'(mpc));
        check("valid", 64'(valid), 64'(e_valid));
        if (e_valid) check("uopOut", uopOut, sb[0]);
        else         check("uopOut_idle", uopOut, 64'h0);
        s_reqv  = imemReqValid;
        s_addr  = imemReqAddr;
        s_valid = valid;
        s_pc    = uopOut.pc;
        s_uop   = uopOut;
        @(posedge clk);
        if (r) begin
            mem_q.delete();
            sb.delete();
            mpc = c_RESET_PC;
        end else begin
            if (e_valid && !s && !rd) void'(sb.pop_front());
            if (resp_now) begin
                h = mem_q.pop_front();
                if (!h.killed && !rd) sb.push_back({h.addr, mdata(h.addr)});
            end
            if (rd) begin
                sb.delete();
                foreach (mem_q[i]) mem_q[i].killed = 1'b1;
                mpc = {rpc[31:2], 2'b00};
            end else if (e_reqv && rdy) begin
                mem_q.push_back('{addr: mpc, killed: 1'b0});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic wait_pc(input string nm, input logic [31:0] exp);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (s_valid) begin
                found = 1'b1;
                check(nm, 64'(s_pc), 64'(exp));
            end
        end
        if (!found) begin
            nvec++;
            nfail++;
            $display("FAIL %s: got no valid uop expected pc %h", nm, exp);
        end
    endtask

    function automatic vec_t mk(bit s, bit rdy, bit rsp, bit chk, bit erv,
                                logic [31:0] ea, bit ev, logic [31:0] ep);
        vec_t v;
        v.stall = s;   v.ready = rdy; v.resp = rsp; v.redir = 1'b0; v.rpc = '0;
        v.chk = chk;   v.e_reqv = erv; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];

        // Free-run after reset: credit pattern repeats every three cycles.
        tbl.push_back(mk(0, 1, 1, 1, 1, 32'h00, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 32'h04, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 32'h08, 1, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 32'h08, 1, 32'h4));
        tbl.push_back(mk(0, 1, 1, 1, 1, 32'h0C, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 32'h10, 1, 32'h8));
        tbl.push_back(mk(0, 1, 1, 1, 1, 32'h10, 1, 32'hC));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("rst_reqValid", 64'(s_reqv), 64'h0);
        check("rst_valid", 64'(s_valid), 64'h0);
        check("rst_uop", s_uop, 64'h0);

        foreach (tbl[i]) begin
            step(tbl[i].stall, tbl[i].ready, tbl[i].resp, tbl[i].redir, tbl[i].rpc, 1'b0);
            if (tbl[i].chk) begin
                check("tbl_reqValid", 64'(s_reqv), 64'(tbl[i].e_reqv));
                check("tbl_reqAddr", 64'(s_addr), 64'(tbl[i].e_addr));
                check("tbl_valid", 64'(s_valid), 64'(tbl[i].e_valid));
                if (tbl[i].e_valid) check("tbl_pc", 64'(s_pc), 64'(tbl[i].e_pc));
            end
        end

        // Two requests outstanding, then redirect: both responses must vanish.
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("two_inflight_noreq", 64'(s_reqv), 64'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
        wait_pc("redir_first", 32'h0000_0100);
        wait_pc("redir_second", 32'h0000_0104);

        // Redirect coinciding with a response; unaligned target.
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0203, 1'b0);
        wait_pc("redir_resp_first", 32'h0000_0200);
        wait_pc("redir_resp_second", 32'h0000_0204);

        // Back-to-back redirects, then PC wrap at the top of the address space.
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        wait_pc("wrap_top", 32'hFFFF_FFFC);
        wait_pc("wrap_zero", 32'h0000_0000);

        // Reset in the middle of traffic.
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("midrst_valid", 64'(s_valid), 64'h0);
        check("midrst_addr", 64'(s_addr), 64'(c_RESET_PC));

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 3, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 $urandom, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
